// File: rtl/decode_stage.sv
// Registered instruction decode stage: valid/ready on both sides, pending-write
// scoreboard for RAW/WAW stalls, flush, and a saturating hazard-stall counter.
module decode_stage #(
    parameter int unsigned OFF_W = 32,
    parameter int unsigned SB_EN = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_op,
    output logic             out_y_sel,
    output logic             out_write,
    output logic [4:0]       out_addr_a,
    output logic [4:0]       out_addr_b,
    output logic [4:0]       out_addr_d,
    output logic [OFF_W-1:0] out_offset,
    output logic [9:0]       out_offset_lo,
    output logic [4:0]       out_offset_hi,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [6:0]       op_w;
    logic             y_sel_w;
    logic             write_w;
    logic             store_w;
    logic [4:0]       a_w;
    logic [4:0]       b_w;
    logic [4:0]       d_w;
    logic [OFF_W-1:0] offset_w;

    logic [31:0]      sb_q, sb_d;
    logic [31:0]      wb_mask;
    logic [31:0]      eff;
    logic             raw_w;
    logic             waw_w;
    logic             hazard;
    logic             accept;

    logic             out_valid_q, out_valid_d;
    logic [6:0]       out_op_q;
    logic             out_y_sel_q;
    logic             out_write_q;
    logic [4:0]       out_addr_a_q;
    logic [4:0]       out_addr_b_q;
    logic [4:0]       out_addr_d_q;
    logic [OFF_W-1:0] out_offset_q;
    logic [9:0]       out_offset_lo_q;
    logic [4:0]       out_offset_hi_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign op_w     = in_ir[31:25];
    assign d_w      = in_ir[24:20];
    assign a_w      = in_ir[19:15];
    assign b_w      = in_ir[14:10];
    assign y_sel_w  = (op_w[6:2] != 5'b00100);
    assign write_w  = (op_w <= 7'h11);
    assign store_w  = (op_w == 7'h12) || (op_w == 7'h13);
    assign offset_w = OFF_W'($signed(in_ir[14:0]));

    // Same-cycle writeback is bypassed into the hazard view; bit 0 is never set.
    assign wb_mask = wb_valid ? (32'd1 << wb_addr) : '0;
    assign eff     = sb_q & ~wb_mask;

    assign raw_w  = eff[a_w] | (y_sel_w & eff[b_w]) | (store_w & eff[d_w]);
    assign waw_w  = write_w & eff[d_w];
    assign hazard = (SB_EN != 0) && (raw_w || waw_w);

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sb_d = eff;
        if (flush && out_valid_q && out_write_q) begin
            sb_d[out_addr_d_q] = 1'b0;
        end
        // Applied after the writeback clear so a same-register set wins.
        if (accept && write_w && (d_w != 5'd0)) begin
            sb_d[d_w] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && hazard && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q        <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sb_q        <= sb_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_op_q        <= '0;
            out_y_sel_q     <= 1'b0;
            out_write_q     <= 1'b0;
            out_addr_a_q    <= '0;
            out_addr_b_q    <= '0;
            out_addr_d_q    <= '0;
            out_offset_q    <= '0;
            out_offset_lo_q <= '0;
            out_offset_hi_q <= '0;
        end else if (accept) begin
            out_op_q        <= op_w;
            out_y_sel_q     <= y_sel_w;
            out_write_q     <= write_w;
            out_addr_a_q    <= a_w;
            out_addr_b_q    <= b_w;
            out_addr_d_q    <= d_w;
            out_offset_q    <= offset_w;
            out_offset_lo_q <= in_ir[9:0];
            out_offset_hi_q <= in_ir[24:20];
        end
    end

    assign out_valid     = out_valid_q;
    assign out_op        = out_op_q;
    assign out_y_sel     = out_y_sel_q;
    assign out_write     = out_write_q;
    assign out_addr_a    = out_addr_a_q;
    assign out_addr_b    = out_addr_b_q;
    assign out_addr_d    = out_addr_d_q;
    assign out_offset    = out_offset_q;
    assign out_offset_lo = out_offset_lo_q;
    assign out_offset_hi = out_offset_hi_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; a second instance with a
// 4-bit stall counter shares all inputs to observe saturation.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_ir;
    logic        out_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;

    logic        in_ready;
    logic        out_valid;
    logic [6:0]  out_op;
    logic        out_y_sel;
    logic        out_write;
    logic [4:0]  out_addr_a;
    logic [4:0]  out_addr_b;
    logic [4:0]  out_addr_d;
    logic [31:0] out_offset;
    logic [9:0]  out_offset_lo;
    logic [4:0]  out_offset_hi;
    logic [15:0] stall_cnt;

    logic        u4_in_ready;
    logic        u4_out_valid;
    logic [6:0]  u4_out_op;
    logic        u4_out_y_sel;
    logic        u4_out_write;
    logic [4:0]  u4_out_addr_a;
    logic [4:0]  u4_out_addr_b;
    logic [4:0]  u4_out_addr_d;
    logic [31:0] u4_out_offset;
    logic [9:0]  u4_out_offset_lo;
    logic [4:0]  u4_out_offset_hi;
    logic [3:0]  u4_stall_cnt;

    int errors = 0;
    int checks = 0;

    decode_stage #(.OFF_W(32), .SB_EN(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_y_sel(out_y_sel), .out_write(out_write),
        .out_addr_a(out_addr_a), .out_addr_b(out_addr_b), .out_addr_d(out_addr_d),
        .out_offset(out_offset), .out_offset_lo(out_offset_lo),
        .out_offset_hi(out_offset_hi), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    decode_stage #(.OFF_W(32), .SB_EN(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u4_in_ready),
        .in_ir(in_ir), .out_valid(u4_out_valid), .out_ready(out_ready),
        .out_op(u4_out_op), .out_y_sel(u4_out_y_sel), .out_write(u4_out_write),
        .out_addr_a(u4_out_addr_a), .out_addr_b(u4_out_addr_b),
        .out_addr_d(u4_out_addr_d), .out_offset(u4_out_offset),
        .out_offset_lo(u4_out_offset_lo), .out_offset_hi(u4_out_offset_hi),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
        .stall_cnt(u4_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                       input logic [4:0] a, input logic [4:0] b,
                                       input logic [9:0] lo);
        return {op, d, a, b, lo};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
        wb_addr = 5'd0; out_ready = 1'b1; in_ir = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_ir = mk(7'h10, 5'd7, 5'd1, 5'd2, 10'h155);
        out_ready = 1'b0; wb_valid = 1'b0; wb_addr = 5'd0; flush = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++;
        if ({out_op, out_y_sel, out_write, out_addr_a, out_addr_b, out_addr_d, out_offset_lo, out_offset_hi} !== '0) begin
            errors++; $display("FAIL reset_fields got op=%h d=%0d exp all zero", out_op, out_addr_d);
        end
        checks++;
        if (out_offset !== 32'h0) begin errors++; $display("FAIL reset_offset got=%h exp=0", out_offset); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        reset = 1'b0; in_valid = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_flush got=%b exp=0", in_ready); end
        flush = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_opcode_sweep();
        logic exp_ysel;
        logic exp_write;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            in_valid = 1'b1;
            in_ir = {7'(i), 5'd0, 5'd0, 15'h4000};
            exp_ysel  = !(i >= 16 && i <= 19);
            exp_write = (i < 18);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready op=%h got=%b exp=1", i, in_ready); end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_op !== 7'(i)) begin
                errors++; $display("FAIL sweep_op got v=%b op=%h exp v=1 op=%h", out_valid, out_op, i);
            end
            checks++;
            if (out_y_sel !== exp_ysel) begin errors++; $display("FAIL sweep_ysel op=%h got=%b exp=%b", i, out_y_sel, exp_ysel); end
            checks++;
            if (out_write !== exp_write) begin errors++; $display("FAIL sweep_write op=%h got=%b exp=%b", i, out_write, exp_write); end
            checks++;
            if (out_offset !== 32'hFFFFC000 || out_offset_lo !== 10'd0 || out_addr_b !== 5'd16) begin
                errors++; $display("FAIL sweep_offset op=%h got=%h lo=%h b=%0d exp=ffffc000 lo=0 b=16", i, out_offset, out_offset_lo, out_addr_b);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_ir = mk(7'h00, 5'd1, 5'd10, 5'd11, 10'h001);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got=%b exp=1", in_ready); end
        step();
        out_ready = 1'b0;
        in_ir = mk(7'h00, 5'd2, 5'd12, 5'd13, 10'h002);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_bp_ready cyc=%0d got=%b exp=0", k, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_addr_d !== 5'd1 || out_addr_a !== 5'd10 || out_offset_lo !== 10'h001) begin
                errors++; $display("FAIL b2b_hold cyc=%0d got v=%b d=%0d a=%0d exp v=1 d=1 a=10", k, out_valid, out_addr_d, out_addr_a);
            end
            step();
        end
        checks++;
        if (out_addr_d !== 5'd1 || out_addr_b !== 5'd11) begin errors++; $display("FAIL b2b_hold_end got d=%0d b=%0d exp d=1 b=11", out_addr_d, out_addr_b); end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_release got=%b exp=1", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_addr_d !== 5'd2 || out_addr_a !== 5'd12) begin
            errors++; $display("FAIL b2b_second got v=%b d=%0d a=%0d exp v=1 d=2 a=12", out_valid, out_addr_d, out_addr_a);
        end
        in_ir = mk(7'h00, 5'd3, 5'd14, 5'd15, 10'h003);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_addr_d !== 5'd3 || out_offset_lo !== 10'h003) begin
            errors++; $display("FAIL b2b_third got v=%b d=%0d exp v=1 d=3", out_valid, out_addr_d);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_raw();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_ir = mk(7'h10, 5'd5, 5'd1, 5'd0, 10'h004);
        step();
        in_ir = mk(7'h00, 5'd6, 5'd5, 5'd7, 10'h000);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got=%b exp=0", in_ready); end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (stall_cnt !== 16'(k) || in_ready !== 1'b0) begin
                errors++; $display("FAIL raw_cnt got cnt=%0d rdy=%b exp cnt=%0d rdy=0", stall_cnt, in_ready, k);
            end
        end
        wb_valid = 1'b1; wb_addr = 5'd5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass got=%b exp=1", in_ready); end
        step();
        wb_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr_d !== 5'd6 || out_op !== 7'h00 || stall_cnt !== 16'd3) begin
            errors++; $display("FAIL raw_accept got v=%b d=%0d cnt=%0d exp v=1 d=6 cnt=3", out_valid, out_addr_d, stall_cnt);
        end
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        in_ir = mk(7'h14, 5'd0, 5'd5, 5'd0, 10'h000);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_r5_clear got=%b exp=1", in_ready); end
        in_ir = mk(7'h14, 5'd0, 5'd1, 5'd6, 10'h000);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_r6_pending got=%b exp=0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_waw();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_ir = mk(7'h00, 5'd3, 5'd0, 5'd0, 10'h000);
        step();
        in_ir = mk(7'h01, 5'd3, 5'd0, 5'd0, 10'h000);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got=%b exp=0", in_ready); end
        wb_valid = 1'b1; wb_addr = 5'd3;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_bypass got=%b exp=1", in_ready); end
        step();
        wb_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_op !== 7'h01) begin errors++; $display("FAIL waw_accept got v=%b op=%h exp v=1 op=01", out_valid, out_op); end
        in_ir = mk(7'h14, 5'd0, 5'd3, 5'd0, 10'h000);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_set_wins got=%b exp=0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_ir = mk(7'h00, 5'd4, 5'd0, 5'd0, 10'h000);
        step();
        in_ir = mk(7'h10, 5'd9, 5'd1, 5'd0, 10'h000);
        step();
        out_ready = 1'b0; flush = 1'b1;
        in_ir = mk(7'h14, 5'd0, 5'd1, 5'd0, 10'h000);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_addr_d !== 5'd9) begin errors++; $display("FAIL flush_held got v=%b d=%0d exp v=1 d=9", out_valid, out_addr_d); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        in_valid = 1'b1;
        in_ir = mk(7'h14, 5'd0, 5'd9, 5'd0, 10'h000);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_r9_clear got=%b exp=1", in_ready); end
        in_ir = mk(7'h14, 5'd0, 5'd4, 5'd0, 10'h000);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_r4_kept got=%b exp=0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_r0_saturation();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_ir = mk(7'h00, 5'd0, 5'd0, 5'd0, 10'h000);
        step();
        in_ir = mk(7'h01, 5'd0, 5'd0, 5'd0, 10'h000);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL r0_nostall got=%b exp=1", in_ready); end
        step();
        in_ir = mk(7'h10, 5'd8, 5'd0, 5'd0, 10'h000);
        step();
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL r0_cnt got=%0d exp=0", stall_cnt); end
        in_ir = mk(7'h14, 5'd0, 5'd8, 5'd0, 10'h000);
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 13) begin
                checks++;
                if (u4_stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_mid got=%0d exp=14", u4_stall_cnt); end
            end
        end
        checks++;
        if (u4_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got=%0d exp=15", u4_stall_cnt); end
        checks++;
        if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16 got=%0d exp=20", stall_cnt); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'd0 || u4_stall_cnt !== 4'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midstall_reset got cnt=%0d cnt4=%0d v=%b exp 0 0 0", stall_cnt, u4_stall_cnt, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midstall_ready got=%b exp=1", in_ready); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_opcode_sweep();
        test_back_to_back();
        test_raw();
        test_waw();
        test_flush();
        test_r0_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction decode stage with valid/ready handshakes on both sides and a per-register pending-write scoreboard. It sits between fetch and register-read/execute and replaces the purely combinational field splitter. It adds pipelining, back-pressure, RAW/WAW hazard stalls, flush and a stall counter, and generalises the offset width.

## Interface
Parameters:
- OFF_W, 32: width of sign-extended `out_offset` (must be ≥ 15).
- SB_EN, 1: 1 enables the scoreboard; 0 means the hazard signal is tied to 0.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch offers `in_ir`.
- `in_ready`  out  1  stage accepts `in_ir` this cycle.
- `in_ir`  in  32  instruction word.
- `out_valid`  out  1  decoded instruction held.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_op`  out  7  `ir[31:25]`.
- `out_y_sel`  out  1  0 = offset operand, 1 = src2 operand.
- `out_write`  out  1  instruction writes `rd`.
- `out_addr_a`, `out_addr_b`, `out_addr_d`  out  5 each  `ir[19:15]`, `ir[14:10]`, `ir[24:20]`.
- `out_offset`  out  OFF_W  `ir[14:0]` sign-extended.
- `out_offset_lo`  out  10  `ir[9:0]`.
- `out_offset_hi`  out  5  `ir[24:20]`.
- `wb_valid`  in  1  writeback retires a register write.
- `wb_addr`  in  5  register being written back.
- `flush`  in  1  discard the held instruction.
- `stall_cnt`  out  CNT_W  cycles with `in_valid`=1 and `in_ready`=0 due to hazard.

## Operation
Decode rules, with op = `ir[31:25]`:
- `y_sel` = 0 for op ∈ {0x10, 0x11, 0x12, 0x13}; otherwise 1.
- `write` = 1 for op ≤ 0x11; otherwise 0. This covers ALU ops 0x00–0x0F and loads 0x10/0x11. Stores 0x12/0x13 and all ops ≥ 0x14 do not write.

Sources read by each instruction:
- `addr_a` always.
- `addr_b` when `y_sel`=1.
- `addr_d` when op ∈ {0x12, 0x13} (store data).

Register 0 is never tracked or hazarded.

Scoreboard:
- Holds 31 pending bits, one per register 1–31.
- Effective view = stored bits with the `wb_addr` bit cleared when `wb_valid` (same-cycle writeback bypass).

Hazard condition (combinational on `in_ir`), asserted when either:
- any used source has its effective bit set (RAW), or
- `write`=1 and `addr_d` has its effective bit set (WAW).

Handshake:
- `in_ready` = (!`out_valid` | `out_ready`) & !hazard & !`flush`.

On accept (`in_valid` & `in_ready`):
- Output registers load the decoded fields and `out_valid` ← 1.
- If `write`=1 and `addr_d`≠0, the pending bit for `addr_d` is set.
- Set and a same-cycle writeback clear of the same register resolve to set.

When `out_valid` & `out_ready` with no new accept, `out_valid` ← 0.

Flush:
- `out_valid` ← 0.
- If the held instruction had `out_write`=1, its `out_addr_d` pending bit is cleared.
- Other pending bits are unchanged.
- No accept occurs that cycle.

`stall_cnt` increments when `in_valid` & hazard & !`flush`, and saturates at all-ones.

A `wb_valid` to a non-pending register, or to register 0, has no effect.

## Timing
- Latency is 1 cycle: the instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 instruction/cycle while there is no hazard and `out_ready`=1.
- `in_ready` depends combinationally on `out_ready`, `flush`, `in_ir` and `wb_*`.
- While `out_valid`=1 and `out_ready`=0, all `out_*` fields stay stable.
- Reset takes priority over all other inputs. It drives:
  - `out_valid`=0 and every `out_*` field = 0;
  - scoreboard cleared;
  - `stall_cnt`=0.
- The cycle after reset, `in_ready`=1 unless `flush` is asserted.
- Reset mid-stall drops the held instruction and all pending bits.

## Test plan
- Opcode sweep: each op 0x00–0x7F with `ir[14:0]`=0x4000. Required: `y_sel`/`write` per the rules above and `out_offset`=0xFFFFC000 at OFF_W=32.
- Back-pressure: 3 back-to-back independent ADDs with `out_ready`=0 for 2 cycles. Required: `in_ready`=0, outputs held stable, and all 3 delivered in order with no loss or duplication.
- RAW: load r5 (op 0x10) then ADD r6←r5,r7. Required: ADD stalls and `stall_cnt` increments each cycle until `wb_valid` with `wb_addr`=5. ADD is accepted in the same cycle as that writeback.
- WAW + set-over-clear: with r3 pending, an instruction writing r3 is accepted in the same cycle as the r3 writeback. Required: the r3 bit remains 1.
- Flush: a held load r9 with `flush`=1. Required: `out_valid`=0 next cycle, r9 bit cleared, and `in_ready`=0 during the flush cycle.
- r0 and saturation: writes to r0 never stall. Force CNT_W=4 and hold a hazard for 20 cycles. Required: `stall_cnt`=15.
